pwm_capture: RTL

//  Receive-side counterpart of the 11-bit PWM generator. Measures high time and period of an

---
 rtl/pwm_capture.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input in clk cycles.
// A missing period for TIMEOUT cycles reports a stuck input together with its level.
module pwm_capture #(
   parameter int CNT_W   = 12,
   parameter int TIMEOUT = 4000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] duty,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_lvl
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEAS_HI = 2'd1,
      MEAS_LO = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             s1, s2, s3;
   logic             rise, fall;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_lat;
   logic             tmo_hit;
   logic             publish;
   logic             hi_cap;
   logic             tmo_pulse;

   // s1/s2 resolve metastability; s3 only provides the previous level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         per_cnt <= '0;
      else if (rise)
         per_cnt <= CNT_W'(1);
      else if (per_cnt != CNT_MAX)
         per_cnt <= per_cnt + CNT_W'(1);
   end

   // A rise on the timeout cycle wins, so the timeout term excludes it.
   assign tmo_hit = (per_cnt == TMO_VAL) && !rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = MEAS_HI;
         MEAS_HI: begin
            if (tmo_hit)   state_d = IDLE;
            else if (fall) state_d = MEAS_LO;
         end
         MEAS_LO: begin
            if (rise)         state_d = MEAS_HI;
            else if (tmo_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // In IDLE a timeout only strobes valid on the first entry into stuck.
   always_comb begin
      publish   = 1'b0;
      hi_cap    = 1'b0;
      tmo_pulse = 1'b0;
      case (state_q)
         IDLE:    tmo_pulse = tmo_hit && !stuck;
         MEAS_HI: begin
            hi_cap    = fall && !tmo_hit;
            tmo_pulse = tmo_hit;
         end
         MEAS_LO: begin
            publish   = rise;
            tmo_pulse = tmo_hit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hi_lat <= '0;
      else if (hi_cap)
         hi_lat <= per_cnt;
   end

   // per_cnt still holds the full period on the publish cycle; the reload lands on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty      <= '0;
         period    <= '0;
         valid     <= 1'b0;
         stuck     <= 1'b0;
         stuck_lvl <= 1'b0;
      end else begin
         valid <= publish | tmo_pulse;
         if (publish) begin
            duty   <= hi_lat;
            period <= per_cnt;
            stuck  <= 1'b0;
         end else if (tmo_hit) begin
            stuck     <= 1'b1;
            stuck_lvl <= s2;
            duty      <= s2 ? CNT_MAX : '0;
            period    <= CNT_MAX;
         end
      end
   end

endmodule
